uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an internal TX FIFO, selectable data width, runtime parity mode and runtime stop-bit count. Upstream logic pushes words through a valid/ready handshake. The block serialises each word as start, data LSB first, optional parity, then stop bits, on a single line. It is the next-generation TX path for the loopback and UART command designs.

---
 rtl/uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with an internal TX FIFO. Upstream logic pushes words
//   through a valid/ready handshake; each word is sent as a start bit, the
//   data bits LSB first, an optional parity bit and one or two stop bits.
//   Parity and stop-bit settings are sampled when a word leaves the FIFO and
//   are held for that whole frame.
//
// Ports
//   sysclk       : system clock, all logic on the rising edge
//   rst          : synchronous active-high reset
//   tx_data      : word to enqueue
//   tx_valid     : tx_data is valid this cycle
//   tx_ready     : FIFO can accept a word (not full)
//   parity_sel   : 00/11 none, 01 even, 10 odd
//   stop_sel     : 0 = one stop bit, 1 = two stop bits
//   uart_tx      : registered serial line, idles high
//   uart_tx_done : one-cycle pulse after the last stop-bit cycle of a frame
//   uart_tx_busy : high while a frame is on the line
//   fifo_level   : number of words currently held in the FIFO
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sysclk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [1:0]                  parity_sel,
  input  logic                        stop_sel,
  output logic                        uart_tx,
  output logic                        uart_tx_done,
  output logic                        uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int LW         = AW + 1;
  localparam int CW         = $clog2(BIT_PERIOD);
  localparam int IW         = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wrPtr_q;
  logic [AW-1:0]         rdPtr_q;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_d;

  // Serialiser state
  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         bitIdx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  parityBit_q;
  logic                  parEn_q;
  logic                  stop2_q;
  logic                  stopIdx_q;
  logic                  uartTx_q;
  logic                  busy_q;
  logic                  donePend_q;
  logic                  done_q;

  logic                  push;
  logic                  pop;
  logic                  bitEnd;
  logic                  lastStop;
  logic                  frameEnd;
  logic                  lineBit;
  logic [DATA_WIDTH-1:0] headWord;

  // tx_ready looks only at the registered level, so a pop on the same edge
  // never opens a slot for a push while the FIFO is full.
  assign tx_ready = (level_q != LW'(FIFO_DEPTH));
  assign push     = tx_valid && tx_ready;
  assign headWord = mem_q[rdPtr_q];

  assign bitEnd   = (cnt_q == '0);
  assign lastStop = !stop2_q || stopIdx_q;
  assign frameEnd = (state_q == STOP) && bitEnd && lastStop;

  // A word is taken from the FIFO when idle, or straight out of the final
  // stop cycle so back-to-back frames have no idle gap.
  assign pop = (level_q != '0) && ((state_q == IDLE) || frameEnd);

  // Level update: push and pop on the same edge cancel out.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage needs no reset; stale entries are never read because the
  // pointers and level are cleared.
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem_q[wrPtr_q] <= tx_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // Line level for the bit the FSM is currently timing.
  always_comb begin
    lineBit = 1'b1;
    case (state_q)
      START:   lineBit = 1'b0;
      DATA:    lineBit = shift_q[0];
      PARITY:  lineBit = parityBit_q;
      default: lineBit = 1'b1;
    endcase
  end

  // Frame FSM. The outputs are registered copies of what the FSM did in the
  // cycle just ended, so the line, busy and done all trail the state by one
  // cycle and stay aligned with each other. done passes through one extra
  // stage so it lands on the cycle after the last stop-bit cycle on the line.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      parityBit_q <= 1'b0;
      parEn_q     <= 1'b0;
      stop2_q     <= 1'b0;
      stopIdx_q   <= 1'b0;
      uartTx_q    <= 1'b1;
      busy_q      <= 1'b0;
      donePend_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      uartTx_q   <= lineBit;
      busy_q     <= (state_q != IDLE);
      donePend_q <= frameEnd;
      done_q     <= donePend_q;

      if (pop) begin
        // Frame settings are captured here and held until the next pop.
        state_q     <= START;
        cnt_q       <= CW'(BIT_PERIOD - 1);
        bitIdx_q    <= '0;
        stopIdx_q   <= 1'b0;
        shift_q     <= headWord;
        parEn_q     <= parity_sel[0] ^ parity_sel[1];
        parityBit_q <= parity_sel[1] ? ~^headWord : ^headWord;
        stop2_q     <= stop_sel;
      end else begin
        case (state_q)
          START: begin
            if (bitEnd) begin
              state_q  <= DATA;
              cnt_q    <= CW'(BIT_PERIOD - 1);
              bitIdx_q <= '0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          DATA: begin
            if (bitEnd) begin
              cnt_q   <= CW'(BIT_PERIOD - 1);
              shift_q <= shift_q >> 1;
              if (bitIdx_q == IW'(DATA_WIDTH - 1)) begin
                state_q   <= parEn_q ? PARITY : STOP;
                stopIdx_q <= 1'b0;
              end else begin
                bitIdx_q <= bitIdx_q + IW'(1);
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          PARITY: begin
            if (bitEnd) begin
              state_q   <= STOP;
              cnt_q     <= CW'(BIT_PERIOD - 1);
              stopIdx_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          STOP: begin
            if (bitEnd) begin
              if (lastStop) begin
                state_q <= IDLE;
              end else begin
                stopIdx_q <= 1'b1;
                cnt_q     <= CW'(BIT_PERIOD - 1);
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign uart_tx      = uartTx_q;
  assign uart_tx_done = done_q;
  assign uart_tx_busy = busy_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with CLK_FREQ=1000 and BAUD_RATE=100, so
//   every bit lasts 10 cycles. An 8-bit instance carries most of the work and
//   a 7-bit instance covers the narrow data width. Each bit is sampled at its
//   first and last cycle so both the value and the exact bit length are
//   pinned down.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       sysclk;
  logic       rst;
  logic [1:0] paritySel;
  logic       stopSel;

  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       uartTx;
  logic       uartTxDone;
  logic       uartTxBusy;
  logic [4:0] fifoLevel;

  logic [6:0] txData7;
  logic       txValid7;
  logic       txReady7;
  logic       uartTx7;
  logic       uartTxDone7;
  logic       uartTxBusy7;
  logic [4:0] fifoLevel7;

  int compared;
  int mismatched;

  uart_tx_fifo #(
    .DATA_WIDTH(8),
    .CLK_FREQ  (1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(16)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .tx_data     (txData),
    .tx_valid    (txValid),
    .tx_ready    (txReady),
    .parity_sel  (paritySel),
    .stop_sel    (stopSel),
    .uart_tx     (uartTx),
    .uart_tx_done(uartTxDone),
    .uart_tx_busy(uartTxBusy),
    .fifo_level  (fifoLevel)
  );

  uart_tx_fifo #(
    .DATA_WIDTH(7),
    .CLK_FREQ  (1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(16)
  ) dut7 (
    .sysclk      (sysclk),
    .rst         (rst),
    .tx_data     (txData7),
    .tx_valid    (txValid7),
    .tx_ready    (txReady7),
    .parity_sel  (paritySel),
    .stop_sel    (stopSel),
    .uart_tx     (uartTx7),
    .uart_tx_done(uartTxDone7),
    .uart_tx_busy(uartTxBusy7),
    .fifo_level  (fifoLevel7)
  );

  // 10 ns clock
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic lineOf(input int sel);
    return (sel != 0) ? uartTx7 : uartTx;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel != 0) ? uartTxBusy7 : uartTxBusy;
  endfunction

  function automatic logic doneOf(input int sel);
    return (sel != 0) ? uartTxDone7 : uartTxDone;
  endfunction

  // Present one word for exactly one edge.
  task automatic applyStimulus(input int sel, input logic [7:0] data);
    if (sel != 0) begin
      txData7  = data[6:0];
      txValid7 = 1'b1;
    end else begin
      txData  = data;
      txValid = 1'b1;
    end
    tick(1);
    txValid  = 1'b0;
    txValid7 = 1'b0;
  endtask

  // Count cycles until the line drops, bounded so a dead line still ends.
  task automatic waitLow(input string tag, input int sel, input int expCycles);
    int cnt;
    cnt = 0;
    while (lineOf(sel) !== 1'b0 && cnt < 50) begin
      tick(1);
      cnt++;
    end
    checkOutput({tag, " latency"}, cnt, expCycles);
  endtask

  // Called on the first cycle of a start bit; returns on the cycle right after
  // the last stop-bit cycle. par: 0 none, 1 even, 2 odd. At bit chgBit the
  // parity select is switched to chgPar to probe mid-frame reconfiguration.
  task automatic checkFrame(input string tag, input int sel, input logic [8:0] data,
                            input int nData, input int par, input int nStop,
                            input int chgBit, input logic [1:0] chgPar);
    logic [15:0] bits;
    logic        p;
    int          total;
    p    = 1'b0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nData; i++) begin
      p           = p ^ data[i];
      bits[1 + i] = data[i];
    end
    total = 1 + nData;
    if (par != 0) begin
      bits[total] = (par == 1) ? p : ~p;
      total++;
    end
    total = total + nStop;
    for (int k = 0; k < total; k++) begin
      if (k == chgBit) begin
        paritySel = chgPar;
      end
      checkOutput($sformatf("%s bit%0d head", tag, k), lineOf(sel), bits[k]);
      checkOutput($sformatf("%s bit%0d busy", tag, k), busyOf(sel), 1'b1);
      tick(9);
      checkOutput($sformatf("%s bit%0d tail", tag, k), lineOf(sel), bits[k]);
      checkOutput($sformatf("%s bit%0d nodone", tag, k), doneOf(sel), 1'b0);
      tick(1);
    end
    checkOutput({tag, " done"}, doneOf(sel), 1'b1);
  endtask

  initial begin
    int bad;
    int accepted;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    paritySel  = 2'b00;
    stopSel    = 1'b0;
    txData     = '0;
    txValid    = 1'b0;
    txData7    = '0;
    txValid7   = 1'b0;

    // Reset then idle
    tick(3);
    rst = 1'b0;
    checkOutput("reset tx", uartTx, 1'b1);
    checkOutput("reset busy", uartTxBusy, 1'b0);
    checkOutput("reset done", uartTxDone, 1'b0);
    checkOutput("reset level", fifoLevel, 5'd0);
    checkOutput("reset ready", txReady, 1'b1);
    checkOutput("reset tx7", uartTx7, 1'b1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (uartTx !== 1'b1 || uartTxBusy !== 1'b0 || uartTxDone !== 1'b0 ||
          fifoLevel !== 5'd0 || txReady !== 1'b1) begin
        bad++;
      end
    end
    checkOutput("idle hold", bad, 0);

    // 8N1 single word 0x55
    applyStimulus(0, 8'h55);
    waitLow("8N1", 0, 2);
    checkFrame("8N1", 0, 9'h055, 8, 0, 1, -1, 2'b00);
    checkOutput("8N1 idle tx", uartTx, 1'b1);
    checkOutput("8N1 idle busy", uartTxBusy, 1'b0);
    tick(1);
    checkOutput("8N1 done low", uartTxDone, 1'b0);
    tick(2);

    // Parity on 0xA7 (five ones): even -> 1, odd -> 0
    paritySel = 2'b01;
    applyStimulus(0, 8'hA7);
    waitLow("8E1", 0, 2);
    checkFrame("8E1", 0, 9'h0A7, 8, 1, 1, -1, 2'b00);
    tick(3);
    paritySel = 2'b10;
    applyStimulus(0, 8'hA7);
    waitLow("8O1", 0, 2);
    checkFrame("8O1", 0, 9'h0A7, 8, 2, 1, -1, 2'b00);
    tick(3);
    paritySel = 2'b01;
    stopSel   = 1'b1;
    applyStimulus(0, 8'hA7);
    waitLow("8E2", 0, 2);
    checkFrame("8E2", 0, 9'h0A7, 8, 1, 2, -1, 2'b00);
    checkOutput("8E2 idle busy", uartTxBusy, 1'b0);
    tick(3);

    // FIFO full: a frame is already on the line so nothing pops during the burst
    paritySel = 2'b00;
    stopSel   = 1'b0;
    applyStimulus(0, 8'h3C);
    waitLow("full pre", 0, 2);
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      txData  = 8'(i);
      txValid = 1'b1;
      if (txReady === 1'b1) begin
        accepted++;
      end
      tick(1);
    end
    txValid = 1'b0;
    checkOutput("full accepted", accepted, 16);
    checkOutput("full level", fifoLevel, 5'd16);
    checkOutput("full ready", txReady, 1'b0);
    tick(80);
    checkOutput("full pre done", uartTxDone, 1'b1);
    checkOutput("full drain level", fifoLevel, 5'd15);
    for (int j = 0; j < 16; j++) begin
      checkFrame($sformatf("full w%0d", j), 0, 9'(j), 8, 0, 1, -1, 2'b00);
      checkOutput($sformatf("full w%0d level", j), fifoLevel, (j < 15) ? 14 - j : 0);
    end
    checkOutput("full end tx", uartTx, 1'b1);
    checkOutput("full end busy", uartTxBusy, 1'b0);
    tick(3);

    // Mid-frame parity change only affects the following frame
    applyStimulus(0, 8'h0F);
    applyStimulus(0, 8'h33);
    waitLow("reconf", 0, 1);
    checkFrame("reconf A", 0, 9'h00F, 8, 0, 1, 3, 2'b01);
    checkFrame("reconf B", 0, 9'h033, 8, 1, 1, -1, 2'b00);
    checkOutput("reconf end tx", uartTx, 1'b1);
    tick(3);

    // Reset mid-frame with words queued
    paritySel = 2'b00;
    applyStimulus(0, 8'h11);
    applyStimulus(0, 8'h22);
    applyStimulus(0, 8'h33);
    waitLow("rstmid", 0, 0);
    tick(30);
    checkOutput("rstmid level before", fifoLevel, 5'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("rstmid tx", uartTx, 1'b1);
    checkOutput("rstmid level", fifoLevel, 5'd0);
    checkOutput("rstmid done", uartTxDone, 1'b0);
    checkOutput("rstmid busy", uartTxBusy, 1'b0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (uartTx !== 1'b1 || uartTxDone !== 1'b0 || fifoLevel !== 5'd0) begin
        bad++;
      end
    end
    checkOutput("rstmid quiet", bad, 0);

    // 7-bit instance: 0x7F gives seven ones and a 9-bit frame
    applyStimulus(1, 8'h7F);
    waitLow("7N1", 1, 2);
    checkFrame("7N1", 1, 9'h07F, 7, 0, 1, -1, 2'b00);
    checkOutput("7N1 idle tx", uartTx7, 1'b1);
    checkOutput("7N1 idle busy", uartTxBusy7, 1'b0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
